// File: rtl/vector_compare_err_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : vector_compare_err_counter_if
// Description : Beat bus carrying one PARALLELISM-wide slice of the reference
//               codeword and the matching slice from the decoder under test.
//               master : beat source (drives the beat)
//               slave  : error counter (consumes the beat)
//               in_valid   - beat present this cycle
//               in_first   - beat is beat 0 of a new word
//               in_vec_ref - expected bits, lane i = word bit (beat*P + i)
//               in_vec_dut - decoder output bits, same lane mapping
// Revision    : 1.0 - initial release
// ============================================================================
interface vector_compare_err_counter_if #(
    parameter int PARALLELISM = 1
);
    localparam int P = (PARALLELISM < 1) ? 1 : PARALLELISM;

    logic         in_valid;
    logic         in_first;
    logic [P-1:0] in_vec_ref;
    logic [P-1:0] in_vec_dut;

    modport master (output in_valid, in_first, in_vec_ref, in_vec_dut);
    modport slave  (input  in_valid, in_first, in_vec_ref, in_vec_dut);
endinterface
`default_nettype wire

// File: rtl/vector_compare_err_counter.sv
`default_nettype none
// ============================================================================
// Module      : vector_compare_err_counter
// Description : Bit-error checker for the BCH decoder verification path.
//               XORs each reference beat against the decoder beat, masks the
//               unused lanes of a word's final beat, accumulates a per-word
//               error count and publishes word and running-total statistics.
// Ports       : clk                - rising-edge clock
//               in_Arst            - asynchronous active-high reset
//               in_clr             - synchronous clear, highest priority
//               beat_if            - beat bus (slave side)
//               out_word_done      - pulse, word-level outputs updated
//               out_word_bit_err   - bit errors of last completed word
//               out_word_err       - last completed word had errors
//               out_word_cnt       - completed words (saturating)
//               out_total_word_err - completed words with errors (saturating)
//               out_total_bit_err  - sum of bit errors (saturating)
//               out_proto_err      - pulse on a framing violation
//               out_busy           - a word is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module vector_compare_err_counter #(
    parameter int PARALLELISM = 1,
    parameter int WORD_LEN    = 1023,
    parameter int TOTAL_W     = 32,
    localparam int P          = (PARALLELISM < 1) ? 1 : PARALLELISM,
    localparam int BEATS      = (WORD_LEN + P - 1) / P,
    localparam int LAST_VALID = ((WORD_LEN % P) == 0) ? P : (WORD_LEN % P),
    localparam int CNT_W      = $clog2(WORD_LEN + 1),
    localparam int BEAT_W     = $clog2(BEATS + 1)
) (
    input  wire logic                 clk,
    input  wire logic                 in_Arst,
    input  wire logic                 in_clr,
    vector_compare_err_counter_if.slave beat_if,
    output logic                      out_word_done,
    output logic [CNT_W-1:0]          out_word_bit_err,
    output logic                      out_word_err,
    output logic [TOTAL_W-1:0]        out_word_cnt,
    output logic [TOTAL_W-1:0]        out_total_word_err,
    output logic [TOTAL_W-1:0]        out_total_bit_err,
    output logic                      out_proto_err,
    output logic                      out_busy
);

    localparam int SUM_W = ((TOTAL_W > CNT_W) ? TOTAL_W : CNT_W) + 1;
    localparam logic [TOTAL_W-1:0] TOT_MAX   = '1;
    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BEATS - 1);

    // Lanes beyond the end of the codeword on the final beat carry padding.
    function automatic logic [P-1:0] f_last_mask();
        logic [P-1:0] m;
        for (int i = 0; i < P; i++) begin
            m[i] = (i < LAST_VALID);
        end
        return m;
    endfunction

    localparam logic [P-1:0] LAST_MASK = f_last_mask();

    function automatic logic [TOTAL_W-1:0] f_sat_add(
        input logic [TOTAL_W-1:0] a,
        input logic [CNT_W-1:0]   b
    );
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'(TOT_MAX)) begin
            return TOT_MAX;
        end
        return s[TOTAL_W-1:0];
    endfunction

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [CNT_W-1:0]     acc_q, acc_d;
    logic                 word_done_q, word_done_d;
    logic [CNT_W-1:0]     word_bit_err_q, word_bit_err_d;
    logic                 word_err_q, word_err_d;
    logic [TOTAL_W-1:0]   word_cnt_q, word_cnt_d;
    logic [TOTAL_W-1:0]   total_word_err_q, total_word_err_d;
    logic [TOTAL_W-1:0]   total_bit_err_q, total_bit_err_d;
    logic                 proto_err_q, proto_err_d;

    logic                 w_is_last;
    logic [P-1:0]         w_diff;
    logic [CNT_W-1:0]     w_beat_err;
    logic                 w_complete;
    logic [CNT_W-1:0]     w_final_sum;

    // An in_first beat is always beat 0 regardless of where the counter is.
    assign w_is_last = beat_if.in_first ? (BEATS == 1) : (beat_q == LAST_BEAT);

    always_comb begin
        w_diff     = beat_if.in_vec_ref ^ beat_if.in_vec_dut;
        if (w_is_last) begin
            w_diff = w_diff & LAST_MASK;
        end
        w_beat_err = '0;
        for (int i = 0; i < P; i++) begin
            w_beat_err = w_beat_err + CNT_W'(w_diff[i]);
        end
    end

    always_comb begin
        state_d          = state_q;
        beat_d           = beat_q;
        acc_d            = acc_q;
        word_done_d      = 1'b0;
        word_bit_err_d   = word_bit_err_q;
        word_err_d       = word_err_q;
        word_cnt_d       = word_cnt_q;
        total_word_err_d = total_word_err_q;
        total_bit_err_d  = total_bit_err_q;
        proto_err_d      = 1'b0;
        w_complete       = 1'b0;
        w_final_sum      = '0;

        if (in_clr) begin
            state_d          = S_IDLE;
            beat_d           = '0;
            acc_d            = '0;
            word_bit_err_d   = '0;
            word_err_d       = 1'b0;
            word_cnt_d       = '0;
            total_word_err_d = '0;
            total_bit_err_d  = '0;
        end else if (beat_if.in_valid) begin
            if (beat_if.in_first) begin
                // A restart while a word is open drops the partial word.
                if (state_q == S_ACTIVE) begin
                    proto_err_d = 1'b1;
                end
                if (BEATS == 1) begin
                    w_complete  = 1'b1;
                    w_final_sum = w_beat_err;
                    state_d     = S_IDLE;
                    beat_d      = '0;
                    acc_d       = '0;
                end else begin
                    acc_d   = w_beat_err;
                    beat_d  = BEAT_W'(1);
                    state_d = S_ACTIVE;
                end
            end else if (state_q == S_IDLE) begin
                proto_err_d = 1'b1;
            end else if (beat_q == LAST_BEAT) begin
                w_complete  = 1'b1;
                w_final_sum = acc_q + w_beat_err;
                state_d     = S_IDLE;
                beat_d      = '0;
                acc_d       = '0;
            end else begin
                acc_d  = acc_q + w_beat_err;
                beat_d = beat_q + BEAT_W'(1);
            end
        end

        if (w_complete) begin
            word_done_d      = 1'b1;
            word_bit_err_d   = w_final_sum;
            word_err_d       = (w_final_sum != '0);
            word_cnt_d       = f_sat_add(word_cnt_q, CNT_W'(1));
            total_word_err_d = f_sat_add(total_word_err_q, CNT_W'(w_final_sum != '0));
            total_bit_err_d  = f_sat_add(total_bit_err_q, w_final_sum);
        end
    end

    always_ff @(posedge clk or posedge in_Arst) begin
        if (in_Arst) begin
            state_q          <= S_IDLE;
            beat_q           <= '0;
            acc_q            <= '0;
            word_done_q      <= 1'b0;
            word_bit_err_q   <= '0;
            word_err_q       <= 1'b0;
            word_cnt_q       <= '0;
            total_word_err_q <= '0;
            total_bit_err_q  <= '0;
            proto_err_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            beat_q           <= beat_d;
            acc_q            <= acc_d;
            word_done_q      <= word_done_d;
            word_bit_err_q   <= word_bit_err_d;
            word_err_q       <= word_err_d;
            word_cnt_q       <= word_cnt_d;
            total_word_err_q <= total_word_err_d;
            total_bit_err_q  <= total_bit_err_d;
            proto_err_q      <= proto_err_d;
        end
    end

    assign out_word_done      = word_done_q;
    assign out_word_bit_err   = word_bit_err_q;
    assign out_word_err       = word_err_q;
    assign out_word_cnt       = word_cnt_q;
    assign out_total_word_err = total_word_err_q;
    assign out_total_bit_err  = total_bit_err_q;
    assign out_proto_err      = proto_err_q;
    assign out_busy           = (state_q == S_ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_vector_compare_err_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_compare_err_counter
// Description : Self-checking bench. Two instances with WORD_LEN=15, P=4
//               (BEATS=4, LAST_VALID=3); instance A uses 32-bit totals,
//               instance B 4-bit totals for saturation. Both see the same
//               beat stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_compare_err_counter;

    localparam int P       = 4;
    localparam int WL      = 15;
    localparam int CNT_W   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic         t_valid = 1'b0;
    logic         t_first = 1'b0;
    logic [P-1:0] t_ref   = '0;
    logic [P-1:0] t_dut   = '0;

    always #5 clk = ~clk;

    vector_compare_err_counter_if #(.PARALLELISM(P)) if_a ();
    vector_compare_err_counter_if #(.PARALLELISM(P)) if_b ();

    assign if_a.in_valid   = t_valid;
    assign if_a.in_first   = t_first;
    assign if_a.in_vec_ref = t_ref;
    assign if_a.in_vec_dut = t_dut;
    assign if_b.in_valid   = t_valid;
    assign if_b.in_first   = t_first;
    assign if_b.in_vec_ref = t_ref;
    assign if_b.in_vec_dut = t_dut;

    logic             a_done, a_werr, a_proto, a_busy;
    logic [CNT_W-1:0] a_wbits;
    logic [31:0]      a_cnt, a_twerr, a_tbits;
    logic             b_done, b_werr, b_proto, b_busy;
    logic [CNT_W-1:0] b_wbits;
    logic [3:0]       b_cnt, b_twerr, b_tbits;

    vector_compare_err_counter #(.PARALLELISM(P), .WORD_LEN(WL), .TOTAL_W(32)) u_dut_a (
        .clk                (clk),
        .in_Arst            (rst),
        .in_clr             (clr),
        .beat_if            (if_a.slave),
        .out_word_done      (a_done),
        .out_word_bit_err   (a_wbits),
        .out_word_err       (a_werr),
        .out_word_cnt       (a_cnt),
        .out_total_word_err (a_twerr),
        .out_total_bit_err  (a_tbits),
        .out_proto_err      (a_proto),
        .out_busy           (a_busy)
    );

    vector_compare_err_counter #(.PARALLELISM(P), .WORD_LEN(WL), .TOTAL_W(4)) u_dut_b (
        .clk                (clk),
        .in_Arst            (rst),
        .in_clr             (clr),
        .beat_if            (if_b.slave),
        .out_word_done      (b_done),
        .out_word_bit_err   (b_wbits),
        .out_word_err       (b_werr),
        .out_word_cnt       (b_cnt),
        .out_total_word_err (b_twerr),
        .out_total_bit_err  (b_tbits),
        .out_proto_err      (b_proto),
        .out_busy           (b_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_pulses  = 0;
    int proto_pulses = 0;

    // Pulse counters sample 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (a_done)  done_pulses  = done_pulses + 1;
        if (a_proto) proto_pulses = proto_pulses + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic [P-1:0] r, input logic [P-1:0] d);
        @(negedge clk);
        t_valid = v;
        t_first = f;
        t_ref   = r;
        t_dut   = d;
    endtask

    task automatic beat(input logic f, input logic [P-1:0] diff);
        logic [P-1:0] r;
        r = P'($urandom);
        drive(1'b1, f, r, r ^ diff);
    endtask

    task automatic gap();
        drive(1'b0, 1'b0, P'($urandom), P'($urandom));
    endtask

    task automatic word(input logic [P-1:0] d0, input logic [P-1:0] d1,
                        input logic [P-1:0] d2, input logic [P-1:0] d3);
        beat(1'b1, d0);
        beat(1'b0, d1);
        beat(1'b0, d2);
        beat(1'b0, d3);
        gap();
    endtask

    task automatic do_clear();
        @(negedge clk);
        t_valid = 1'b0;
        clr     = 1'b1;
        @(negedge clk);
        clr     = 1'b0;
    endtask

    typedef struct {
        logic [P-1:0] d0, d1, d2, d3;
        int           bits;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int exp_cnt, exp_werr, exp_bits, ds, ps;

        // Beat 3 carries word bits 12..15; lane 3 is padding and is ignored.
        tbl[0] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 0};
        tbl[1] = '{4'b0101, 4'b0000, 4'b0000, 4'b1001, 3};
        tbl[2] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 15};
        tbl[3] = '{4'b1000, 4'b0000, 4'b0001, 4'b1000, 2};
        tbl[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 0};
        tbl[5] = '{4'b0000, 4'b0110, 4'b0000, 4'b0111, 5};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_done",  32'(a_done),  0);
        chk("reset_cnt",   a_cnt,        0);
        chk("reset_tbits", a_tbits,      0);
        chk("reset_twerr", a_twerr,      0);
        chk("reset_wbits", 32'(a_wbits), 0);
        chk("reset_busy",  32'(a_busy),  0);
        chk("reset_proto", 32'(a_proto), 0);

        // Table of single words, totals accumulated across the table.
        exp_cnt = 0; exp_werr = 0; exp_bits = 0;
        for (int i = 0; i < 6; i++) begin
            word(tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3);
            exp_cnt  = exp_cnt + 1;
            exp_werr = exp_werr + ((tbl[i].bits != 0) ? 1 : 0);
            exp_bits = exp_bits + tbl[i].bits;
            chk($sformatf("tbl%0d_done", i),  32'(a_done),  1);
            chk($sformatf("tbl%0d_wbits", i), 32'(a_wbits), 32'(tbl[i].bits));
            chk($sformatf("tbl%0d_werr", i),  32'(a_werr),  (tbl[i].bits != 0) ? 1 : 0);
            chk($sformatf("tbl%0d_cnt", i),   a_cnt,        32'(exp_cnt));
            chk($sformatf("tbl%0d_twerr", i), a_twerr,      32'(exp_werr));
            chk($sformatf("tbl%0d_tbits", i), a_tbits,      32'(exp_bits));
            gap();
            chk($sformatf("tbl%0d_done_pulse", i), 32'(a_done), 0);
            chk($sformatf("tbl%0d_wbits_hold", i), 32'(a_wbits), 32'(tbl[i].bits));
        end

        // Gaps mid-word, then a back-to-back second word.
        do_clear();
        chk("clr_cnt", a_cnt, 0);
        ds = done_pulses;
        beat(1'b1, 4'b0011);
        repeat (3) gap();
        chk("gap_busy", 32'(a_busy), 1);
        chk("gap_nodone", 32'(a_done), 0);
        beat(1'b0, 4'b0000);
        repeat (3) gap();
        beat(1'b0, 4'b0000);
        beat(1'b0, 4'b0000);
        beat(1'b1, 4'b0000);
        beat(1'b0, 4'b0000);
        beat(1'b0, 4'b0000);
        beat(1'b0, 4'b0000);
        gap();
        gap();
        chk("b2b_done_pulses", 32'(done_pulses - ds), 2);
        chk("b2b_tbits", a_tbits, 2);
        chk("b2b_twerr", a_twerr, 1);
        chk("b2b_cnt",   a_cnt,   2);
        chk("b2b_wbits", 32'(a_wbits), 0);

        // Restart inside a word, then a stray beat in IDLE.
        do_clear();
        ps = proto_pulses;
        beat(1'b1, 4'b1111);
        beat(1'b0, 4'b1111);
        beat(1'b1, 4'b0000);
        beat(1'b0, 4'b0000);
        beat(1'b0, 4'b0000);
        beat(1'b0, 4'b0000);
        gap();
        chk("abort_proto", 32'(proto_pulses - ps), 1);
        chk("abort_cnt",   a_cnt, 1);
        chk("abort_wbits", 32'(a_wbits), 0);
        chk("abort_tbits", a_tbits, 0);
        beat(1'b0, 4'b1111);
        gap();
        chk("stray_proto_pulse", 32'(a_proto), 1);
        gap();
        chk("stray_proto", 32'(proto_pulses - ps), 2);
        chk("stray_cnt",   a_cnt, 1);
        chk("stray_busy",  32'(a_busy), 0);

        // Saturation on the 4-bit instance.
        do_clear();
        for (int i = 0; i < 17; i++) begin
            word(4'b1111, 4'b1111, 4'b1111, 4'b1111);
        end
        chk("sat_b_tbits", 32'(b_tbits), 15);
        chk("sat_b_cnt",   32'(b_cnt),   15);
        chk("sat_b_twerr", 32'(b_twerr), 15);
        chk("sat_b_wbits", 32'(b_wbits), 15);
        chk("sat_a_tbits", a_tbits, 255);
        chk("sat_a_cnt",   a_cnt,   17);

        // Asynchronous reset in the middle of beat 2.
        do_clear();
        word(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        beat(1'b1, 4'b0011);
        beat(1'b0, 4'b0000);
        beat(1'b0, 4'b0000);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cnt",   a_cnt, 0);
        chk("arst_tbits", a_tbits, 0);
        chk("arst_busy",  32'(a_busy), 0);
        chk("arst_wbits", 32'(a_wbits), 0);
        @(negedge clk);
        t_valid = 1'b0;
        rst = 1'b0;
        word(4'b0000, 4'b0100, 4'b0000, 4'b0010);
        chk("arst_next_cnt",   a_cnt, 1);
        chk("arst_next_tbits", a_tbits, 2);

        // Synchronous clear in the middle of beat 2.
        beat(1'b1, 4'b0011);
        beat(1'b0, 4'b0000);
        beat(1'b0, 4'b0000);
        clr = 1'b1;
        #1;
        chk("clr_pre_busy", 32'(a_busy), 1);
        chk("clr_pre_cnt",  a_cnt, 1);
        @(negedge clk);
        clr = 1'b0;
        t_valid = 1'b0;
        chk("clr_post_busy",  32'(a_busy), 0);
        chk("clr_post_cnt",   a_cnt, 0);
        chk("clr_post_tbits", a_tbits, 0);
        word(4'b1000, 4'b0000, 4'b0000, 4'b0001);
        chk("clr_next_cnt",   a_cnt, 1);
        chk("clr_next_wbits", 32'(a_wbits), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
